latch_capture_ctrl: RTL and testbench

Upstream controller for a bank of transparent D latches. It accepts a data word through a ready/req handshake and drives the latch bank's data and enable pins in a fixed sequence: setup, open window, hold. The sequence guarantees that latch_d is stable before, during and after every latch_en pulse. latch_en comes straight from a flop and is glitch-free, so it can drive latch enable pins directly.

---
 rtl/latch_ctrl_pkg.sv | 14 +
 rtl/phase_counter.sv | 27 ++
 rtl/latch_capture_ctrl.sv | 139 +++++++++++++
 tb/tb_latch_capture_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch capture controller: sequencer state encoding.
package latch_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing each phase of the latch sequence; zero marks the phase's last cycle.
module phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_capture_ctrl.sv
// Drives a transparent latch bank: captures a word, then sequences setup, enable window and hold
// so latch_d is stable around every glitch-free, flop-driven latch_en pulse.
module latch_capture_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] latch_d,
    output logic             latch_en
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (OPEN_CYC < 1) begin : g_bad_open
        $error("latch_capture_ctrl: OPEN_CYC must be >= 1");
    end
    if (SETUP_CYC < 0 || SETUP_CYC > CNT_MAX || HOLD_CYC < 0 || HOLD_CYC > CNT_MAX ||
        OPEN_CYC > CNT_MAX) begin : g_bad_len
        $error("latch_capture_ctrl: phase length does not fit CNT_W");
    end

    // Counter holds (phase length - 1) on entry, so a 1-cycle phase exits on its first edge.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'((OPEN_CYC > 0) ? OPEN_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] latch_d_q;
    logic             latch_en_q, latch_en_d;
    logic             capture;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .value (cnt_value),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous abort is irrelevant here: nothing is in flight yet.
                if (req) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
                    if (SETUP_CYC > 0) begin
                        state_d   = SETUP;
                        cnt_value = SETUP_LD;
                    end else begin
                        state_d   = OPEN;
                        cnt_value = OPEN_LD;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d   = OPEN;
                    cnt_load  = 1'b1;
                    cnt_value = OPEN_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            OPEN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    if (HOLD_CYC > 0) begin
                        state_d   = HOLD;
                        cnt_load  = 1'b1;
                        cnt_value = HOLD_LD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enable is registered from the next state so it is a clean flop output aligned with OPEN.
    assign latch_en_d = (state_d == OPEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            latch_d_q  <= '0;
            latch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            latch_en_q <= latch_en_d;
            if (capture) begin
                latch_d_q <= data_in;
            end
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign latch_d  = latch_d_q;
    assign latch_en = latch_en_q;

endmodule

// File: tb/tb_latch_capture_ctrl.sv
// Bench for latch_capture_ctrl: timeline reference model and done-pulse scoreboard on the default
// build, plus directed checks on a zero-setup/zero-hold build.
module tb_latch_capture_ctrl;

    localparam int S = 1;
    localparam int O = 2;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] data_in = '0;
    logic       abort = 1'b0;
    logic       ready, busy, done, latch_en;
    logic [7:0] latch_d;

    logic       req_b = 1'b0;
    logic [7:0] data_b = '0;
    logic       ready_b, busy_b, done_b, latch_en_b;
    logic [7:0] latch_d_b;

    always #5 clk = ~clk;

    latch_capture_ctrl #(.WIDTH(8), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .latch_d(latch_d), .latch_en(latch_en)
    );

    latch_capture_ctrl #(.WIDTH(8), .SETUP_CYC(0), .OPEN_CYC(1), .HOLD_CYC(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(data_b), .abort(1'b0),
        .ready(ready_b), .busy(busy_b), .done(done_b), .latch_d(latch_d_b), .latch_en(latch_en_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a sequence is described only by its accept edge and captured word.
    int         cyc = 0;
    bit         active = 0;
    int         acc = 0;
    logic [7:0] mdl_d = '0;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 0;
            mdl_d  = '0;
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            cyc++;
            if (active) begin
                if (cyc - 1 - acc == S + O + H) begin
                    active = 0;
                end else if (abort) begin
                    active = 0;
                    void'(exp_q.pop_back());
                    void'(exp_cyc_q.pop_back());
                end
            end else if (req) begin
                active = 1;
                acc    = cyc;
                mdl_d  = data_in;
                exp_q.push_back(data_in);
                exp_cyc_q.push_back(cyc + S + O + H);
            end
        end
    end

    // Monitor: compares levels every cycle and pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        int  r;
        bit  e_en;
        r    = cyc - acc;
        e_en = active && (r >= S) && (r < S + O);
        check("latch_en", latch_en, e_en);
        check("busy",     busy,     active);
        check("ready",    ready,    !active);
        check("latch_d",  latch_d,  mdl_d);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("done_data",  latch_d, exp_q.pop_front());
                check("done_cycle", cyc,     exp_cyc_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        req     = 1'b1;
        data_in = d;
        @(negedge clk);
        req     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready",    ready,    1);
        check("rst_busy",     busy,     0);
        check("rst_latch_en", latch_en, 0);
        check("rst_latch_d",  latch_d,  8'h00);
        check("rst_done",     done,     0);
        rst_n = 1'b1;

        // Zero-setup/zero-hold build: enable for exactly one cycle, done the next.
        @(negedge clk);
        req_b  = 1'b1;
        data_b = 8'hFF;
        @(negedge clk);
        req_b  = 1'b0;
        check("b_en_k",     latch_en_b, 1);
        check("b_done_k",   done_b,     0);
        check("b_d_k",      latch_d_b,  8'hFF);
        @(negedge clk);
        check("b_en_k1",    latch_en_b, 0);
        check("b_done_k1",  done_b,     1);
        check("b_busy_k1",  busy_b,     1);
        @(negedge clk);
        check("b_ready_k2", ready_b,    1);
        check("b_done_k2",  done_b,     0);
        check("b_d_k2",     latch_d_b,  8'hFF);

        // Nominal sequence with a second req arriving during OPEN; it must be ignored.
        issue(8'hA5);
        @(negedge clk);
        req     = 1'b1;
        data_in = 8'h3C;
        @(negedge clk);
        req     = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_ignore_d", latch_d, 8'hA5);

        // Abort on the first enabled cycle.
        issue(8'h5A);
        check("abort_pre_en", latch_en, 0);
        @(negedge clk);
        check("abort_in_open", latch_en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_en",    latch_en, 0);
        check("abort_ready", ready,    1);
        check("abort_d",     latch_d,  8'h5A);
        repeat (4) @(negedge clk);

        // Asynchronous reset between edges while the enable is high.
        issue(8'hC3);
        @(posedge clk);
        #2;
        check("async_pre_en", latch_en, 1);
        rst_n = 1'b0;
        #1;
        check("async_en", latch_en, 0);
        check("async_d",  latch_d,  8'h00);
        check("async_done", done,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("async_ready", ready, 1);

        // Random traffic with occasional aborts, checked by the model and scoreboard.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req     = ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom_range(0, 255));
            abort   = ($urandom_range(0, 11) == 0);
        end
        @(negedge clk);
        req   = 1'b0;
        abort = 1'b0;
        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
